// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the multiply/divide engine: operation
// codes, data widths and the operand magnitude helper.
package muldiv_unit_pkg;

    localparam int DATA_W   = 32;
    localparam int DIV_ITER = 32;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'd0,
        MD_OP_MULTU = 2'd1,
        MD_OP_DIV   = 2'd2,
        MD_OP_DIVU  = 2'd3
    } md_op_e;

    // Absolute value when the operand is treated as signed; raw value otherwise.
    function automatic logic [DATA_W-1:0] operand_mag(input logic [DATA_W-1:0] v,
                                                      input logic              is_signed);
        operand_mag = (is_signed && v[DATA_W-1]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide engine.
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic              flush;
    logic              start;
    logic [1:0]        md_op;
    logic [DATA_W-1:0] operand_1;
    logic [DATA_W-1:0] operand_2;
    logic              stall_req;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport slave (
        input  flush, start, md_op, operand_1, operand_2,
        output stall_req, done, hi, lo
    );

    modport master (
        output flush, start, md_op, operand_1, operand_2,
        input  stall_req, done, hi, lo
    );

endinterface

// File: rtl/muldiv_unit_divider_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes. The step result is
// exposed combinationally so the final quotient is usable on the last iteration edge.
module divider_core
    import muldiv_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              abort_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              valid_o
);

    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;

    logic [DATA_W:0]   shifted_s;
    logic [DATA_W:0]   diff_s;
    logic [DATA_W-1:0] rem_d;
    logic [DATA_W-1:0] quo_d;

    // One shift-subtract step; bit 32 of the difference is the borrow.
    always_comb begin
        shifted_s = {rem_q, quo_q[DATA_W-1]};
        diff_s    = shifted_s - {1'b0, dvs_q};
        rem_d     = shifted_s[DATA_W-1:0];
        quo_d     = {quo_q[DATA_W-2:0], 1'b0};
        if (!diff_s[DATA_W]) begin
            rem_d = diff_s[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_d = shifted_s[DATA_W-1:0];
        end
    end

    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;
    assign valid_o     = busy_q && (cnt_q == CNT_W'(DIV_ITER - 1));

    // Load, iterate and abort control for the partial remainder registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= dividend_i;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_q + 5'd1;
            busy_q <= !valid_o;
        end else begin
            busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage MULT/MULTU/DIV/DIVU engine producing HI/LO, with a stall request
// that holds the issuing instruction until the result is committed.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  md
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_DZERO = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    md_op_e            op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;

    logic              issue_s;
    logic              in_signed_div_s;
    logic              div_start_s;
    logic [DATA_W-1:0] div_quo_s, div_rem_s, fix_quo_s, fix_rem_s;
    logic              div_valid_s;
    logic [2*DATA_W-1:0] ext_a_s, ext_b_s, prod_s;

    assign issue_s         = (state_q == S_IDLE) && md.start && !md.flush;
    assign in_signed_div_s = (md.md_op == MD_OP_DIV);
    assign div_start_s     = issue_s && md.md_op[1] && (md.operand_2 != 32'd0);

    divider_core u_div (
        .clk         (clk),
        .rst         (rst),
        .abort_i     (md.flush),
        .start_i     (div_start_s),
        .dividend_i  (operand_mag(md.operand_1, in_signed_div_s)),
        .divisor_i   (operand_mag(md.operand_2, in_signed_div_s)),
        .quotient_o  (div_quo_s),
        .remainder_o (div_rem_s),
        .valid_o     (div_valid_s)
    );

    // Low 64 bits of a two's-complement product are correct once operands are sign-extended.
    assign ext_a_s   = (op_q == MD_OP_MULT) ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {32'd0, a_q};
    assign ext_b_s   = (op_q == MD_OP_MULT) ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {32'd0, b_q};
    assign prod_s    = ext_a_s * ext_b_s;
    assign fix_quo_s = ((op_q == MD_OP_DIV) && (a_q[DATA_W-1] ^ b_q[DATA_W-1])) ? (32'd0 - div_quo_s) : div_quo_s;
    assign fix_rem_s = ((op_q == MD_OP_DIV) && a_q[DATA_W-1]) ? (32'd0 - div_rem_s) : div_rem_s;

    // Next-state and result commit; flush from any busy state drops the result.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue_s) begin
                    if (!md.md_op[1])                  state_d = S_MUL;
                    else if (md.operand_2 == 32'd0)    state_d = S_DZERO;
                    else                               state_d = S_DIV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (md.flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    hi_d    = prod_s[2*DATA_W-1:DATA_W];
                    lo_d    = prod_s[DATA_W-1:0];
                    done_d  = 1'b1;
                end
            end
            S_DZERO: begin
                if (md.flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    hi_d    = a_q;
                    lo_d    = 32'hFFFF_FFFF;
                    done_d  = 1'b1;
                end
            end
            S_DIV: begin
                if (md.flush) begin
                    state_d = S_IDLE;
                end else if (div_valid_s) begin
                    state_d = S_DONE;
                    hi_d    = fix_rem_s;
                    lo_d    = fix_quo_s;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured operands and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= MD_OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            if (issue_s) begin
                op_q <= md_op_e'(md.md_op);
                a_q  <= md.operand_1;
                b_q  <= md.operand_2;
            end
        end
    end

    assign md.stall_req = issue_s || (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_DZERO);
    assign md.done      = done_q;
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage multiply/divide engine for MULT, MULTU, DIV and DIVU.
- Consumes operand_1 (rs) and operand_2 (rt) as delivered by the decode-stage operand generator through the ID/EX register.
- Produces the HI/LO pair for the HI/LO register file.
- Raises a stall request while an operation is in flight so that the pipeline holds the issuing instruction.

Parameters:
- DIV_ITER, 32, number of radix-2 divide iterations; fixed at the data width and not meant to be overridden.

Ports:
- clk  input  1  system clock; one clock domain, all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  pipeline flush; aborts any in-flight operation.
- start  input  1  request a new operation; sampled only in IDLE.
- md_op  input  `MD_OP_BUS (2)  operation: MULT=0, MULTU=1, DIV=2, DIVU=3.
- operand_1  input  `DATA_BUS (32)  rs value: multiplicand or dividend.
- operand_2  input  `DATA_BUS (32)  rt value: multiplier or divisor.
- stall_req  output  1  combinational hold request to the pipeline controller.
- done  output  1  registered one-cycle pulse; hi and lo are valid during this cycle.
- hi  output  `DATA_BUS (32)  registered HI result: product[63:32] or remainder.
- lo  output  `DATA_BUS (32)  registered LO result: product[31:0] or quotient.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE; hi=0, lo=0, done=0; internal divider registers cleared.
  - stall_req=0 in the following cycle.
  - rst overrides flush and start, and is honoured mid-operation.
- States and transitions:
  - IDLE: start=1 → MUL if md_op is MULT or MULTU.
  - IDLE: start=1 → DIV if md_op is DIV or DIVU and operand_2≠0.
  - IDLE: start=1 → DZERO if md_op is DIV or DIVU and operand_2==0.
  - MUL → DONE after 1 cycle.
  - DZERO → DONE after 1 cycle.
  - DIV → DONE after DIV_ITER cycles; iteration counter runs 0..31.
  - DONE → IDLE unconditionally. A start seen in DONE is ignored; the pipeline reissues it from IDLE.
- Operand capture:
  - Operands and md_op are latched on the IDLE→busy edge.
  - Input changes after that edge have no effect on the operation.
- Multiply:
  - Signed (MULT) or unsigned (MULTU) 32x32→64.
  - hi/lo loaded on the MUL→DONE edge.
- Divide:
  - Restoring shift-subtract on magnitudes, 33-bit partial remainder.
  - DIV signed fix-up on the final edge: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0. No trap is raised.
  - Divide by zero: hi=operand_1 and lo=0xFFFFFFFF for both signed and unsigned. No exception is raised.
- Latency, counting from the edge that samples start:
  - done is high in cycle +2 for multiply and divide-by-zero.
  - done is high in cycle +33 for divide.
  - hi/lo change only on the edge that enters DONE, and hold their value otherwise.
- stall_req = (state==IDLE & start & ~flush) | state∈{MUL, DIV, DZERO}.
  - It is low in DONE, so the stalled instruction advances in the cycle where done=1.
- flush:
  - In any busy state: next state is IDLE; hi/lo are not updated; done stays 0.
  - In IDLE with start=1: the request is dropped.
  - In DONE: results are already committed; the state still returns to IDLE.
- start while busy is ignored; there is no queueing.

Decomposition:
- Add to bus.v: `MD_OP_BUS [1:0]`, and the MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV and MD_OP_DIVU codes.
- The FSM state encoding stays local.
- Sub-module divider_core: iterative unsigned divider.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, valid.
- Sign handling and the multiplier remain in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF×0x00000002 → hi=0x00000001, lo=0xFFFFFFFE; done at cycle +2; stall_req high for exactly 2 cycles.
- MULT 0xFFFFFFFD(−3)×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF at cycle +33. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x12345678/0 → hi=0x12345678, lo=0xFFFFFFFF; done at cycle +2.
- DIV started, flush at cycle +10 → state IDLE next cycle, done never pulses, hi/lo keep their prior values; a fresh MULTU 3×4 issued immediately after → lo=12.
- rst asserted mid-divide → hi=lo=0, done=0, stall_req=0 the next cycle. start held high throughout a divide → only one operation is executed per IDLE visit.
